// File: rtl/id_ex_stage_if.sv
// Decode-to-execute handshake bundle: decode-side request and execute-side operand bundle.
// The slave modport is the pipeline register; the master is the surrounding pipeline.
interface id_ex_stage_if #(
  parameter int unsigned CTRL_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_pc;
  logic [4:0]        in_rs1_addr;
  logic [4:0]        in_rs2_addr;
  logic [4:0]        in_rd_addr;
  logic              in_rd_we;
  logic              in_is_load;
  logic [31:0]       in_imm;
  logic [CTRL_W-1:0] in_ctrl;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       out_rs1_val;
  logic [31:0]       out_rs2_val;
  logic [4:0]        out_rd_addr;
  logic              out_rd_we;
  logic              out_is_load;
  logic [31:0]       out_imm;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rd_we, in_is_load,
           in_imm, in_ctrl, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val, out_rd_addr, out_rd_we,
           out_is_load, out_imm, out_ctrl
  );

  modport slave (
    input  in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rd_we, in_is_load,
           in_imm, in_ctrl, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val, out_rd_addr, out_rd_we,
           out_is_load, out_imm, out_ctrl
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: register-file addressing, MEM/WB forwarding, load-use stalls
// and a registered valid/ready operand bundle towards execute.
module id_ex_stage #(
  parameter int unsigned CTRL_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  id_ex_stage_if.slave bus,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,
  input  logic        mem_fwd_we,
  input  logic        mem_fwd_is_load,
  input  logic [4:0]  mem_fwd_rd,
  input  logic [31:0] mem_fwd_data,
  input  logic        wb_fwd_we,
  input  logic [4:0]  wb_fwd_rd,
  input  logic [31:0] wb_fwd_data,
  output logic [31:0] stall_cnt
);

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_pc_q, out_pc_d;
  logic [31:0]       out_rs1_val_q, out_rs1_val_d;
  logic [31:0]       out_rs2_val_q, out_rs2_val_d;
  logic [4:0]        out_rd_addr_q, out_rd_addr_d;
  logic              out_rd_we_q, out_rd_we_d;
  logic              out_is_load_q, out_is_load_d;
  logic [31:0]       out_imm_q, out_imm_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic        hazard;
  logic        in_ready;
  logic        accept;
  logic [31:0] rs1_fwd;
  logic [31:0] rs2_fwd;

  function automatic logic hit(input logic [4:0] a, input logic [4:0] rd);
    return (a != 5'd0) && (a == rd);
  endfunction

  // Load data is never forwarded from MEM; only ALU results are.
  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf_data,
                                      input logic m_we, input logic m_ld,
                                      input logic [4:0] m_rd, input logic [31:0] m_data,
                                      input logic w_we, input logic [4:0] w_rd,
                                      input logic [31:0] w_data);
    if (a == 5'd0)                   return 32'd0;
    else if (m_we && !m_ld && a == m_rd) return m_data;
    else if (w_we && a == w_rd)      return w_data;
    else                             return rf_data;
  endfunction

  assign rf_rs1_addr = bus.in_rs1_addr;
  assign rf_rs2_addr = bus.in_rs2_addr;

  always_comb begin
    hazard = 1'b0;
    if (bus.in_valid) begin
      if (out_valid_q && out_is_load_q && out_rd_we_q &&
          (hit(bus.in_rs1_addr, out_rd_addr_q) || hit(bus.in_rs2_addr, out_rd_addr_q))) begin
        hazard = 1'b1;
      end
      if (mem_fwd_we && mem_fwd_is_load &&
          (hit(bus.in_rs1_addr, mem_fwd_rd) || hit(bus.in_rs2_addr, mem_fwd_rd))) begin
        hazard = 1'b1;
      end
    end
  end

  assign in_ready = reset && !flush && !hazard && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  assign rs1_fwd = fwd(bus.in_rs1_addr, rf_rs1_data, mem_fwd_we, mem_fwd_is_load, mem_fwd_rd,
                       mem_fwd_data, wb_fwd_we, wb_fwd_rd, wb_fwd_data);
  assign rs2_fwd = fwd(bus.in_rs2_addr, rf_rs2_data, mem_fwd_we, mem_fwd_is_load, mem_fwd_rd,
                       mem_fwd_data, wb_fwd_we, wb_fwd_rd, wb_fwd_data);

  always_comb begin
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_rs1_val_d = out_rs1_val_q;
    out_rs2_val_d = out_rs2_val_q;
    out_rd_addr_d = out_rd_addr_q;
    out_rd_we_d   = out_rd_we_q;
    out_is_load_d = out_is_load_q;
    out_imm_d     = out_imm_q;
    out_ctrl_d    = out_ctrl_q;
    stall_cnt_d   = stall_cnt_q;

    if (hazard && !flush) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      out_pc_d      = bus.in_pc;
      out_rs1_val_d = rs1_fwd;
      out_rs2_val_d = rs2_fwd;
      out_rd_addr_d = bus.in_rd_addr;
      out_rd_we_d   = bus.in_rd_we;
      out_is_load_d = bus.in_is_load;
      out_imm_d     = bus.in_imm;
      out_ctrl_d    = bus.in_ctrl;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_rs1_val_q <= '0;
      out_rs2_val_q <= '0;
      out_rd_addr_q <= '0;
      out_rd_we_q   <= 1'b0;
      out_is_load_q <= 1'b0;
      out_imm_q     <= '0;
      out_ctrl_q    <= '0;
      stall_cnt_q   <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_rs1_val_q <= out_rs1_val_d;
      out_rs2_val_q <= out_rs2_val_d;
      out_rd_addr_q <= out_rd_addr_d;
      out_rd_we_q   <= out_rd_we_d;
      out_is_load_q <= out_is_load_d;
      out_imm_q     <= out_imm_d;
      out_ctrl_q    <= out_ctrl_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_rs1_val = out_rs1_val_q;
  assign bus.out_rs2_val = out_rs2_val_q;
  assign bus.out_rd_addr = out_rd_addr_q;
  assign bus.out_rd_we   = out_rd_we_q;
  assign bus.out_is_load = out_is_load_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_ctrl    = out_ctrl_q;
  assign stall_cnt       = stall_cnt_q;

endmodule
